controlador_de_partida: RTL and testbench
=========================================

# controlador_de_partida

Game-sequencing controller for the 5-column × 7-row battleship board. It sits between the player inputs (coordinate switches, confirm and start buttons) and the attack manager. It validates each shot, rejects repeats and out-of-range coordinates, and issues a one-cycle `confirmar` pulse plus the `enable` level to the attack manager. It also counts attempts and hits, and decides victory or defeat.

## Interface
- `MAX_TENTATIVAS`, default 15: attempts allowed per game; legal range 1–63.
- `clock`  in  1: system clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `iniciar`  in  1: start/restart button, synchronous level.
- `botao_confirmar`  in  1: shot button, synchronous level.
- `coordColuna`  in  3: column of the shot; valid range 0–4.
- `coordLinha`  in  3: row of the shot; valid range 0–6.
- `mapa0`..`mapa4`  in  7 each: ship map; column N is `mapaN`, bit [linha] is the row.
- `confirmar`  out  1: one-cycle pulse to the attack manager.
- `enable`  out  1: attack manager enable; low clears the displayed matrix.
- `tentativas`  out  6: attempts consumed this game.
- `acertos`  out  6: hits scored this game.
- `total_navios`  out  6: popcount of the map, latched at game start.
- `acerto`  out  1: one-cycle pulse on a valid shot that hits.
- `invalida`  out  1: one-cycle pulse on an out-of-range or repeated shot.
- `vitoria`  out  1: level, high in VITORIA.
- `derrota`  out  1: level, high in DERROTA.
- `estado`  out  3: current state encoding, for debug and display.

## Operation
- Edge detection: `iniciar` and `botao_confirmar` are each registered once. An event is current level high while the registered level is low, so one press yields one event regardless of how long it is held.
- Internal 35-bit `atacado` register, one bit per cell, indexed as column×7 + row. Coordinates are latched into `col_r`/`lin_r` on the confirm event.
- State encodings: OCIOSO=0, CARREGA=1, JOGANDO=2, VALIDA=3, ATACA=4, VERIFICA=5, VITORIA=6, DERROTA=7.
- OCIOSO: `enable`=0. On an `iniciar` event → CARREGA.
- CARREGA (1 cycle):
  - `total_navios` ← popcount of all 35 map bits.
  - `tentativas`, `acertos`, `atacado` ← 0; `enable`=1.
  - If the popcount is 0 → VITORIA; otherwise → JOGANDO.
- JOGANDO: `enable`=1.
  - On a `botao_confirmar` event: latch the coordinates → VALIDA.
  - An `iniciar` event here is ignored.
- VALIDA (1 cycle):
  - If `col_r`>4, or `lin_r`>6, or the cell's `atacado` bit is 1: pulse `invalida`, consume no attempt → JOGANDO.
  - Otherwise → ATACA.
- ATACA (1 cycle):
  - `confirmar`=1; set the `atacado` bit; `tentativas`+1.
  - If `mapa[col_r][lin_r]`=1: `acertos`+1 and pulse `acerto`.
  - → VERIFICA.
- VERIFICA (1 cycle), checked in this order:
  - `acertos`==`total_navios` → VITORIA.
  - Else `tentativas`==`MAX_TENTATIVAS` → DERROTA.
  - Else → JOGANDO.
  - A hit on the final allowed attempt therefore yields VITORIA.
- VITORIA / DERROTA:
  - `enable`=1, so the final board stays visible; counters hold; shot events are ignored.
  - An `iniciar` event → OCIOSO.
- Counters are 6-bit and never wrap: `tentativas` ≤ `MAX_TENTATIVAS` and `acertos` ≤ 35 by construction.
- The map is sampled live in CARREGA and ATACA. It must be held stable during a game; a changing map is outside the contract.

## Timing
- Reset values:
  - State OCIOSO; all counters, `atacado`, `total_navios` and the edge registers are 0.
  - Outputs `enable`, `confirmar`, `acerto`, `invalida`, `vitoria` and `derrota` are all 0.
- Reset asserted in any state, including mid-ATACA, forces OCIOSO immediately. A `confirmar` pulse in progress is truncated. `enable`=0 clears the attack manager.
- Latency, counted in cycles from the clock edge that registers the button rising edge:
  - `invalida` is high in cycle +1 (VALIDA).
  - `confirmar`, `acerto` and the counter updates are visible in cycle +2 (ATACA).
  - `vitoria`/`derrota` assert in cycle +4.
- Minimum spacing between accepted shots is 4 cycles. A second confirm edge arriving while in VALIDA, ATACA or VERIFICA is dropped.
- `confirmar` is exactly 1 cycle wide and is never asserted outside ATACA.
- Start to play: an `iniciar` edge in OCIOSO gives CARREGA at +1 and JOGANDO at +2. From VITORIA/DERROTA, a new game needs two `iniciar` presses: one to OCIOSO, which clears the board, and one to start.

## Test plan
- Reset then start:
  - Stimulus: map {0x71, 0x20, 0, 0, 0x70}, then an `iniciar` press.
  - Required: `total_navios`=8; `estado` goes 0→1→2; `enable` goes 0→1.
- Single shots on that map:
  - Shot at (0,0): `confirmar` 1-cycle, `acerto`=1, `tentativas`=1, `acertos`=1.
  - Shot at (2,3): `acerto`=0, `tentativas`=2, `acertos`=1.
- Invalid shots:
  - Column 5, row 0 → `invalida` pulse, no `confirmar`, `tentativas` unchanged.
  - Row 7 → same response.
  - Repeat of (2,3) → same response.
- Victory:
  - Map with 2 cells; hit both with `MAX_TENTATIVAS`=2.
  - Required: VITORIA (not DERROTA), `vitoria`=1; further shots ignored.
- Defeat:
  - `MAX_TENTATIVAS`=3, three misses.
  - Required: `derrota`=1, `tentativas`=3; one `iniciar` press → OCIOSO with `enable`=0; a second → CARREGA with counters at 0.
- Corner cases:
  - Empty map at start → VITORIA directly from CARREGA.
  - `reset` asserted during ATACA → all outputs 0 asynchronously.
  - Button held for 20 cycles → exactly one shot.

Source files
------------

// File: rtl/controlador_de_partida_if.sv
// Signal bundle between the player inputs, the game controller and the attack manager.
// master drives player inputs and the ship map; slave is the controller side.
interface controlador_de_partida_if;
  logic       iniciar;
  logic       botao_confirmar;
  logic [2:0] coordColuna;
  logic [2:0] coordLinha;
  logic [6:0] mapa0;
  logic [6:0] mapa1;
  logic [6:0] mapa2;
  logic [6:0] mapa3;
  logic [6:0] mapa4;

  logic       confirmar;
  logic       enable;
  logic [5:0] tentativas;
  logic [5:0] acertos;
  logic [5:0] total_navios;
  logic       acerto;
  logic       invalida;
  logic       vitoria;
  logic       derrota;
  logic [2:0] estado;

  modport master (
    output iniciar, botao_confirmar, coordColuna, coordLinha,
           mapa0, mapa1, mapa2, mapa3, mapa4,
    input  confirmar, enable, tentativas, acertos, total_navios,
           acerto, invalida, vitoria, derrota, estado
  );

  modport slave (
    input  iniciar, botao_confirmar, coordColuna, coordLinha,
           mapa0, mapa1, mapa2, mapa3, mapa4,
    output confirmar, enable, tentativas, acertos, total_navios,
           acerto, invalida, vitoria, derrota, estado
  );
endinterface

// File: rtl/controlador_de_partida.sv
// Battleship game sequencer for a 5x7 board: validates shots, drives the attack
// manager handshake, counts attempts/hits and decides victory or defeat.
module controlador_de_partida #(
  parameter int MAX_TENTATIVAS = 15
) (
  input logic                     clock,
  input logic                     reset,
  controlador_de_partida_if.slave bus
);

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    CARREGA  = 3'd1,
    JOGANDO  = 3'd2,
    VALIDA   = 3'd3,
    ATACA    = 3'd4,
    VERIFICA = 3'd5,
    VITORIA  = 3'd6,
    DERROTA  = 3'd7
  } estado_t;

  localparam logic [5:0] MAX_T = 6'(MAX_TENTATIVAS);

  estado_t     state_reg;
  estado_t     state_next;

  logic        ini_r;
  logic        conf_r;
  logic        ini_ev;
  logic        conf_ev;

  logic [2:0]  col_r;
  logic [2:0]  lin_r;
  logic [34:0] atacado_reg;
  logic [5:0]  tent_reg;
  logic [5:0]  acc_reg;
  logic [5:0]  total_reg;

  logic [6:0]  mapa_col [5];
  logic [34:0] mapa_flat;
  logic [5:0]  popcount;
  logic [5:0]  cell_idx;
  logic        in_range;
  logic        shot_ok;
  logic        hit;

  logic        confirmar_o;
  logic        enable_o;
  logic        acerto_o;
  logic        invalida_o;
  logic        vitoria_o;
  logic        derrota_o;

  assign ini_ev  = bus.iniciar & ~ini_r;
  assign conf_ev = bus.botao_confirmar & ~conf_r;

  assign mapa_col[0] = bus.mapa0;
  assign mapa_col[1] = bus.mapa1;
  assign mapa_col[2] = bus.mapa2;
  assign mapa_col[3] = bus.mapa3;
  assign mapa_col[4] = bus.mapa4;

  // Flatten the map so cell (col, lin) sits at bit col*7 + lin, same as atacado.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_mapa
      assign mapa_flat[gi*7 +: 7] = mapa_col[gi];
    end
  endgenerate

  always_comb begin
    popcount = '0;
    for (int i = 0; i < 35; i++) begin
      popcount = popcount + 6'(mapa_flat[i]);
    end
  end

  // Index is only meaningful when in_range; every use is gated by it.
  assign cell_idx = (6'(col_r) * 6'd7) + 6'(lin_r);
  assign in_range = (col_r <= 3'd4) && (lin_r <= 3'd6);
  assign shot_ok  = in_range && !atacado_reg[cell_idx];
  assign hit      = in_range && mapa_flat[cell_idx];

  always_comb begin
    state_next  = state_reg;
    confirmar_o = 1'b0;
    enable_o    = 1'b1;
    acerto_o    = 1'b0;
    invalida_o  = 1'b0;
    vitoria_o   = 1'b0;
    derrota_o   = 1'b0;
    case (state_reg)
      OCIOSO: begin
        enable_o = 1'b0;
        if (ini_ev) state_next = CARREGA;
      end
      CARREGA: begin
        state_next = (total_reg == 6'd0) ? VITORIA : JOGANDO;
      end
      JOGANDO: begin
        if (conf_ev) state_next = VALIDA;
      end
      VALIDA: begin
        invalida_o = !shot_ok;
        state_next = shot_ok ? ATACA : JOGANDO;
      end
      ATACA: begin
        confirmar_o = 1'b1;
        acerto_o    = hit;
        state_next  = VERIFICA;
      end
      VERIFICA: begin
        if (acc_reg == total_reg)     state_next = VITORIA;
        else if (tent_reg == MAX_T)   state_next = DERROTA;
        else                          state_next = JOGANDO;
      end
      VITORIA: begin
        vitoria_o = 1'b1;
        if (ini_ev) state_next = OCIOSO;
      end
      DERROTA: begin
        derrota_o = 1'b1;
        if (ini_ev) state_next = OCIOSO;
      end
      default: begin
        state_next = OCIOSO;
      end
    endcase
  end

  // Game load and shot bookkeeping happen on the edge entering CARREGA/ATACA so
  // the new counters are already visible while those states are displayed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= OCIOSO;
      ini_r       <= 1'b0;
      conf_r      <= 1'b0;
      col_r       <= '0;
      lin_r       <= '0;
      atacado_reg <= '0;
      tent_reg    <= '0;
      acc_reg     <= '0;
      total_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ini_r     <= bus.iniciar;
      conf_r    <= bus.botao_confirmar;

      if (state_reg == OCIOSO && ini_ev) begin
        total_reg   <= popcount;
        tent_reg    <= '0;
        acc_reg     <= '0;
        atacado_reg <= '0;
      end

      if (state_reg == JOGANDO && conf_ev) begin
        col_r <= bus.coordColuna;
        lin_r <= bus.coordLinha;
      end

      if (state_reg == VALIDA && shot_ok) begin
        atacado_reg[cell_idx] <= 1'b1;
        tent_reg              <= tent_reg + 6'd1;
        if (hit) acc_reg <= acc_reg + 6'd1;
      end
    end
  end

  assign bus.estado       = state_reg;
  assign bus.confirmar    = confirmar_o;
  assign bus.enable       = enable_o;
  assign bus.acerto       = acerto_o;
  assign bus.invalida     = invalida_o;
  assign bus.vitoria      = vitoria_o;
  assign bus.derrota      = derrota_o;
  assign bus.tentativas   = tent_reg;
  assign bus.acertos      = acc_reg;
  assign bus.total_navios = total_reg;

endmodule

// File: tb/tb_controlador_de_partida.sv
// Self-checking bench for controlador_de_partida: directed game scenarios plus
// randomized play, compared every cycle against a shot-level model.
module tb_controlador_de_partida;

  localparam int MAXT = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;

  controlador_de_partida_if intf();

  controlador_de_partida #(.MAX_TENTATIVAS(MAXT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (intf)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  // ---------------- model: one queued entry per busy cycle ----------------
  typedef struct {
    int estado;
    int conf;
    int hit;
    int inv;
    int tent;
    int acc;
  } cyc_t;

  typedef enum {PH_IDLE, PH_PLAY, PH_WON, PH_LOST} phase_t;

  cyc_t   q[$];
  phase_t ph = PH_IDLE;
  int     m_tent = 0;
  int     m_acc = 0;
  int     m_tot = 0;
  bit     m_ini_r = 1'b0;
  bit     m_conf_r = 1'b0;
  bit     m_shot [5][7];
  bit     ie;
  bit     ce;

  function automatic bit map_cell(input int c, input int l);
    logic [6:0] col;
    case (c)
      0:       col = intf.mapa0;
      1:       col = intf.mapa1;
      2:       col = intf.mapa2;
      3:       col = intf.mapa3;
      default: col = intf.mapa4;
    endcase
    return col[l];
  endfunction

  task automatic start_game();
    m_tot  = $countones({intf.mapa4, intf.mapa3, intf.mapa2, intf.mapa1, intf.mapa0});
    m_tent = 0;
    m_acc  = 0;
    foreach (m_shot[c, l]) m_shot[c][l] = 1'b0;
    q.push_back('{estado: 1, conf: 0, hit: 0, inv: 0, tent: 0, acc: 0});
    ph = (m_tot == 0) ? PH_WON : PH_PLAY;
  endtask

  task automatic take_shot(input int c, input int l);
    bit valid;
    bit h;
    valid = (c < 5 && l < 7) ? !m_shot[c][l] : 1'b0;
    if (!valid) begin
      q.push_back('{estado: 3, conf: 0, hit: 0, inv: 1, tent: m_tent, acc: m_acc});
    end else begin
      h = map_cell(c, l);
      q.push_back('{estado: 3, conf: 0, hit: 0, inv: 0, tent: m_tent, acc: m_acc});
      m_shot[c][l] = 1'b1;
      m_tent++;
      if (h) m_acc++;
      q.push_back('{estado: 4, conf: 1, hit: int'(h), inv: 0, tent: m_tent, acc: m_acc});
      q.push_back('{estado: 5, conf: 0, hit: 0, inv: 0, tent: m_tent, acc: m_acc});
      if (m_acc == m_tot)      ph = PH_WON;
      else if (m_tent == MAXT) ph = PH_LOST;
      else                     ph = PH_PLAY;
    end
  endtask

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      q.delete();
      ph = PH_IDLE;
      m_tent = 0;
      m_acc = 0;
      m_tot = 0;
      m_ini_r = 1'b0;
      m_conf_r = 1'b0;
      foreach (m_shot[c, l]) m_shot[c][l] = 1'b0;
    end else begin
      ie = intf.iniciar && !m_ini_r;
      ce = intf.botao_confirmar && !m_conf_r;
      if (q.size() > 0) begin
        void'(q.pop_front());
      end else begin
        case (ph)
          PH_IDLE: if (ie) start_game();
          PH_PLAY: if (ce) take_shot(int'(intf.coordColuna), int'(intf.coordLinha));
          default: if (ie) ph = PH_IDLE;
        endcase
      end
      m_ini_r  = intf.iniciar;
      m_conf_r = intf.botao_confirmar;
    end
  end

  function automatic logic [26:0] expected();
    int est;
    bit en, cf, ht, iv, vi, de;
    int t, a;
    cf = 0; ht = 0; iv = 0; vi = 0; de = 0; en = 1;
    t = m_tent; a = m_acc; est = 0;
    if (q.size() > 0) begin
      est = q[0].estado; cf = q[0].conf[0]; ht = q[0].hit[0]; iv = q[0].inv[0];
      t = q[0].tent; a = q[0].acc;
    end else begin
      case (ph)
        PH_IDLE: begin est = 0; en = 0; end
        PH_PLAY: est = 2;
        PH_WON:  begin est = 6; vi = 1; end
        default: begin est = 7; de = 1; end
      endcase
    end
    return {3'(est), en, cf, ht, iv, vi, de, 6'(t), 6'(a), 6'(m_tot)};
  endfunction

  initial forever begin
    logic [26:0] got;
    logic [26:0] exp;
    @(negedge clock);
    if (!reset) begin
      got = {intf.estado, intf.enable, intf.confirmar, intf.acerto, intf.invalida,
             intf.vitoria, intf.derrota, intf.tentativas, intf.acertos, intf.total_navios};
      exp = expected();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL cycle t=%0t {estado,en,conf,acerto,inv,vit,der,tent,acc,total}: got %h, required %h",
                 $time, got, exp);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press_ini();
    intf.iniciar = 1'b1;
    tick();
    intf.iniciar = 1'b0;
    tick();
  endtask

  task automatic set_map(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c,
                         input logic [6:0] d, input logic [6:0] e);
    intf.mapa0 = a; intf.mapa1 = b; intf.mapa2 = c; intf.mapa3 = d; intf.mapa4 = e;
  endtask

  task automatic shot(input int c, input int l, output int nconf, output int nhit, output int ninv);
    nconf = 0; nhit = 0; ninv = 0;
    intf.coordColuna = 3'(c);
    intf.coordLinha  = 3'(l);
    intf.botao_confirmar = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) intf.botao_confirmar = 1'b0;
      nconf += int'(intf.confirmar);
      nhit  += int'(intf.acerto);
      ninv  += int'(intf.invalida);
    end
    $display("shot (%0d,%0d): confirmar=%0d acerto=%0d invalida=%0d tentativas=%0d acertos=%0d estado=%0d",
             c, l, nconf, nhit, ninv, intf.tentativas, intf.acertos, intf.estado);
  endtask

  int nc, nh, ni, r, found;

  initial begin
    intf.iniciar = 1'b0;
    intf.botao_confirmar = 1'b0;
    intf.coordColuna = '0;
    intf.coordLinha = '0;
    set_map(7'h71, 7'h20, 7'h00, 7'h00, 7'h70);
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("reset estado", intf.estado, 0);
    check("reset enable", intf.enable, 0);
    check("reset tentativas", intf.tentativas, 0);

    // Start: 0 -> 1 -> 2, total = 4+1+3
    intf.iniciar = 1'b1;
    tick();
    check("start estado carrega", intf.estado, 1);
    check("start enable", intf.enable, 1);
    intf.iniciar = 1'b0;
    tick();
    check("start estado jogando", intf.estado, 2);
    check("total_navios", intf.total_navios, 8);
    $display("start: estado=%0d total_navios=%0d", intf.estado, intf.total_navios);

    shot(0, 0, nc, nh, ni);
    check("hit confirmar pulses", nc, 1);
    check("hit acerto", nh, 1);
    check("hit tentativas", intf.tentativas, 1);
    check("hit acertos", intf.acertos, 1);

    shot(2, 3, nc, nh, ni);
    check("miss acerto", nh, 0);
    check("miss tentativas", intf.tentativas, 2);
    check("miss acertos", intf.acertos, 1);

    shot(5, 0, nc, nh, ni);
    check("col5 invalida", ni, 1);
    check("col5 confirmar", nc, 0);
    shot(0, 7, nc, nh, ni);
    check("row7 invalida", ni, 1);
    check("row7 confirmar", nc, 0);
    shot(2, 3, nc, nh, ni);
    check("repeat invalida", ni, 1);
    check("repeat confirmar", nc, 0);
    check("invalid tentativas", intf.tentativas, 2);

    // Third valid miss with MAXT=3 -> defeat
    shot(2, 4, nc, nh, ni);
    check("defeat derrota", intf.derrota, 1);
    check("defeat estado", intf.estado, 7);
    check("defeat tentativas", intf.tentativas, 3);
    intf.iniciar = 1'b1;
    tick();
    check("defeat->ocioso estado", intf.estado, 0);
    check("defeat->ocioso enable", intf.enable, 0);
    intf.iniciar = 1'b0;
    tick();

    // Two-ship map, winning hit on the final allowed attempt
    set_map(7'h00, 7'h01, 7'h00, 7'h40, 7'h00);
    intf.iniciar = 1'b1;
    tick();
    check("restart estado carrega", intf.estado, 1);
    check("restart tentativas", intf.tentativas, 0);
    check("restart acertos", intf.acertos, 0);
    check("restart total", intf.total_navios, 2);
    intf.iniciar = 1'b0;
    tick();
    shot(0, 0, nc, nh, ni);
    shot(1, 0, nc, nh, ni);
    shot(3, 6, nc, nh, ni);
    check("victory vitoria", intf.vitoria, 1);
    check("victory derrota", intf.derrota, 0);
    check("victory estado", intf.estado, 6);
    check("victory acertos", intf.acertos, 2);
    shot(4, 4, nc, nh, ni);
    check("after victory confirmar", nc, 0);
    check("after victory estado", intf.estado, 6);
    check("after victory tentativas", intf.tentativas, 3);

    // Empty map wins straight from CARREGA
    press_ini();
    set_map(7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
    intf.iniciar = 1'b1;
    tick();
    check("empty estado carrega", intf.estado, 1);
    intf.iniciar = 1'b0;
    tick();
    check("empty estado vitoria", intf.estado, 6);
    check("empty total", intf.total_navios, 0);
    $display("empty map: estado=%0d vitoria=%0d", intf.estado, intf.vitoria);

    // Asynchronous reset in the middle of ATACA
    press_ini();
    set_map(7'h71, 7'h20, 7'h00, 7'h00, 7'h70);
    press_ini();
    check("pre-reset estado", intf.estado, 2);
    intf.coordColuna = 3'd1;
    intf.coordLinha = 3'd1;
    intf.botao_confirmar = 1'b1;
    found = 0;
    for (int i = 0; i < 5 && found == 0; i++) begin
      tick();
      intf.botao_confirmar = 1'b0;
      if (intf.estado == 3'd4) found = 1;
    end
    check("reached ataca", found, 1);
    check("ataca confirmar", intf.confirmar, 1);
    #2 reset = 1'b1;
    #1;
    check("async reset confirmar", intf.confirmar, 0);
    check("async reset enable", intf.enable, 0);
    check("async reset estado", intf.estado, 0);
    check("async reset tentativas", intf.tentativas, 0);
    $display("reset in ATACA: estado=%0d confirmar=%0d", intf.estado, intf.confirmar);
    @(posedge clock);
    #1 reset = 1'b0;

    // Button held 20 cycles counts as one shot
    press_ini();
    intf.coordColuna = 3'd3;
    intf.coordLinha = 3'd3;
    intf.botao_confirmar = 1'b1;
    nc = 0;
    repeat (20) begin
      tick();
      nc += int'(intf.confirmar);
    end
    intf.botao_confirmar = 1'b0;
    repeat (4) begin
      tick();
      nc += int'(intf.confirmar);
    end
    check("held confirmar pulses", nc, 1);
    check("held tentativas", intf.tentativas, 1);
    $display("held button: confirmar pulses=%0d tentativas=%0d", nc, intf.tentativas);

    // Randomized play
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (ph == PH_IDLE && q.size() == 0 && r < 40) begin
        if (r < 8)
          set_map(7'h00, 7'(1 << $urandom_range(0, 6)), 7'h00, 7'h00, 7'h00);
        else
          set_map(7'($urandom) & 7'($urandom) & 7'($urandom), 7'($urandom) & 7'($urandom),
                  7'($urandom) & 7'($urandom) & 7'($urandom), 7'($urandom) & 7'($urandom) & 7'($urandom),
                  7'($urandom) & 7'($urandom) & 7'($urandom));
      end
      if (r >= 80) begin
        intf.iniciar = 1'b1;
        repeat ($urandom_range(1, 3)) tick();
        intf.iniciar = 1'b0;
        tick();
        $display("rand %0d: iniciar -> estado=%0d", it, intf.estado);
      end else begin
        intf.coordColuna = 3'($urandom_range(0, 5));
        intf.coordLinha = 3'($urandom_range(0, 7));
        intf.botao_confirmar = 1'b1;
        repeat ($urandom_range(1, 4)) tick();
        intf.botao_confirmar = 1'b0;
        repeat ($urandom_range(0, 4)) tick();
        $display("rand %0d: shot (%0d,%0d) -> estado=%0d tentativas=%0d acertos=%0d", it,
                 intf.coordColuna, intf.coordLinha, intf.estado, intf.tentativas, intf.acertos);
      end
    end
    repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
